// File: rtl/axi4s_arbiter_pkg.sv
// Shared types and helpers for the AXI4-S round-robin arbiter family.
package axi4s_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE_E   = 1'b0,
    ARB_LOCKED_E = 1'b1
  } arb_state_t;

  // Next round-robin pointer: one past the served stream, wrapping at nr.
  function automatic int unsigned rr_next_ptr(input int unsigned ptr, input int unsigned nr);
    return ((ptr + 32'd1) >= nr) ? 32'd0 : (ptr + 32'd1);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: first asserted request at or after
// i_ptr, searching upward with wrap.
module rr_priority_select #(
  parameter int unsigned nr_of_streams_p = 4,
  parameter int unsigned idx_bit_width_p = (nr_of_streams_p > 1) ? $clog2(nr_of_streams_p) : 1
) (
  input  logic [nr_of_streams_p-1:0] i_req,
  input  logic [idx_bit_width_p-1:0] i_ptr,
  output logic                       o_grant_valid,
  output logic [idx_bit_width_p-1:0] o_grant_idx
);

  logic [idx_bit_width_p-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    w_idx         = '0;
    for (int unsigned k = nr_of_streams_p; k > 0; k--) begin
      w_idx = idx_bit_width_p'((32'(i_ptr) + k - 32'd1) % nr_of_streams_p);
      if (i_req[w_idx]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = w_idx;
      end
    end
  end

endmodule

// File: rtl/axi4s_rr_arbiter.sv
// Round-robin AXI4-S arbiter with packet locking and a registered output
// stage; the source stream index is forwarded on tid.
module axi4s_rr_arbiter
  import axi4s_arbiter_pkg::*;
#(
  parameter int unsigned nr_of_streams_p   = 4,
  parameter int unsigned tuser_bit_width_p = 8,
  parameter int unsigned tid_bit_width_p   = (nr_of_streams_p > 1) ? $clog2(nr_of_streams_p) : 1
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  output logic [nr_of_streams_p-1:0]                        axi4s_i_tready,
  input  logic [nr_of_streams_p-1:0]                        axi4s_i_tvalid,
  input  logic [nr_of_streams_p-1:0]                        axi4s_i_tlast,
  input  logic [nr_of_streams_p-1:0][tuser_bit_width_p-1:0] axi4s_i_tuser,
  input  logic                                              axi4s_o_tready,
  output logic                                              axi4s_o_tvalid,
  output logic                                              axi4s_o_tlast,
  output logic [tuser_bit_width_p-1:0]                      axi4s_o_tuser,
  output logic [tid_bit_width_p-1:0]                        axi4s_o_tid
);

  arb_state_t                    r_state;
  logic [tid_bit_width_p-1:0]    r_lock_idx;
  logic [tid_bit_width_p-1:0]    r_rr_ptr;
  logic                          r_o_tvalid;
  logic                          r_o_tlast;
  logic [tuser_bit_width_p-1:0]  r_o_tuser;
  logic [tid_bit_width_p-1:0]    r_o_tid;

  logic                          w_load_ok;
  logic                          w_grant_valid;
  logic [tid_bit_width_p-1:0]    w_grant_idx;
  logic                          w_sel_valid;
  logic [tid_bit_width_p-1:0]    w_sel_idx;
  logic                          w_sel_last;
  logic [nr_of_streams_p-1:0]    w_tready;
  logic                          w_accept;

  rr_priority_select #(
    .nr_of_streams_p (nr_of_streams_p),
    .idx_bit_width_p (tid_bit_width_p)
  ) u_rr_priority_select (
    .i_req         (axi4s_i_tvalid),
    .i_ptr         (r_rr_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  assign w_load_ok   = !r_o_tvalid || axi4s_o_tready;
  assign w_sel_valid = (r_state == ARB_LOCKED_E) ? 1'b1 : w_grant_valid;
  assign w_sel_idx   = (r_state == ARB_LOCKED_E) ? r_lock_idx : w_grant_idx;
  assign w_sel_last  = axi4s_i_tlast[w_sel_idx];

  // Ready goes only to the selected stream; a locked stream keeps the slot even when idle.
  always_comb begin
    w_tready = '0;
    if (rst_n && w_sel_valid && w_load_ok) begin
      w_tready[w_sel_idx] = 1'b1;
    end
  end

  assign w_accept = |(w_tready & axi4s_i_tvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB_IDLE_E;
      r_lock_idx <= '0;
      r_rr_ptr   <= '0;
      r_o_tvalid <= 1'b0;
      r_o_tlast  <= 1'b0;
      r_o_tuser  <= '0;
      r_o_tid    <= '0;
    end else begin
      if (w_accept) begin
        r_o_tvalid <= 1'b1;
        r_o_tlast  <= w_sel_last;
        r_o_tuser  <= axi4s_i_tuser[w_sel_idx];
        r_o_tid    <= w_sel_idx;
        if (w_sel_last) begin
          r_state  <= ARB_IDLE_E;
          r_rr_ptr <= tid_bit_width_p'(rr_next_ptr(32'(w_sel_idx), nr_of_streams_p));
        end else begin
          r_state    <= ARB_LOCKED_E;
          r_lock_idx <= w_sel_idx;
        end
      end else if (axi4s_o_tready) begin
        r_o_tvalid <= 1'b0;
      end
    end
  end

  assign axi4s_i_tready = w_tready;
  assign axi4s_o_tvalid = r_o_tvalid;
  assign axi4s_o_tlast  = r_o_tlast;
  assign axi4s_o_tuser  = r_o_tuser;
  assign axi4s_o_tid    = r_o_tid;

  a_tready_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(axi4s_i_tready));

endmodule

// File: tb/tb_axi4s_rr_arbiter.sv
// Scoreboard bench for axi4s_rr_arbiter: directed scenarios plus a short
// random-traffic phase checked per source stream.
module tb_axi4s_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned TW = 2;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [3:0] gap;
  } beat_t;

  typedef struct packed {
    logic [1:0] tid;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         i_tready;
  logic [N-1:0]         i_tvalid;
  logic [N-1:0]         i_tlast;
  logic [N-1:0][W-1:0]  i_tuser;
  logic                 o_tready;
  logic                 o_tvalid;
  logic                 o_tlast;
  logic [W-1:0]         o_tuser;
  logic [TW-1:0]        o_tid;

  beat_t       src_q [N][$];
  exp_t        sb_q [$];
  exp_t        tid_q [N][$];
  logic [N-1:0] acc;
  int unsigned wait_cnt [N];
  bit          armed [N];
  bit          rand_mode;
  bit          open_pkt;
  logic [1:0]  open_tid;
  int          checks;
  int          errors;

  axi4s_rr_arbiter #(
    .nr_of_streams_p   (N),
    .tuser_bit_width_p (W),
    .tid_bit_width_p   (TW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .axi4s_i_tready (i_tready),
    .axi4s_i_tvalid (i_tvalid),
    .axi4s_i_tlast  (i_tlast),
    .axi4s_i_tuser  (i_tuser),
    .axi4s_o_tready (o_tready),
    .axi4s_o_tvalid (o_tvalid),
    .axi4s_o_tlast  (o_tlast),
    .axi4s_o_tuser  (o_tuser),
    .axi4s_o_tid    (o_tid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=0x%0h required=none", name, act);
  endtask

  function automatic logic [7:0] dv(input int s, input int p, input int b);
    return 8'(16 * s + 4 * p + b);
  endfunction

  task automatic push_src(input int s, input logic [7:0] d, input logic last, input int gap);
    beat_t b;
    b.data = d;
    b.last = last;
    b.gap  = 4'(gap);
    src_q[s].push_back(b);
  endtask

  task automatic push_exp(input int s, input logic [7:0] d, input logic last);
    exp_t e;
    e.tid  = 2'(s);
    e.data = d;
    e.last = last;
    if (rand_mode) tid_q[s].push_back(e);
    else sb_q.push_back(e);
  endtask

  function automatic bit all_empty();
    bit r;
    r = (sb_q.size() == 0);
    for (int s = 0; s < N; s++) begin
      if (src_q[s].size() != 0 || tid_q[s].size() != 0) r = 1'b0;
    end
    return r;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && !all_empty()) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, 32'(all_empty()), 32'd1);
    repeat (2) @(posedge clk);
  endtask

  // Producers: pop on the accept seen last cycle, then present the head beat after its gap.
  initial begin
    i_tvalid = '0;
    i_tlast  = '0;
    i_tuser  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int s = 0; s < N; s++) begin
        if (acc[s] && src_q[s].size() > 0) begin
          void'(src_q[s].pop_front());
          armed[s] = 1'b0;
        end
        i_tvalid[s] = 1'b0;
        if (src_q[s].size() > 0) begin
          if (!armed[s]) begin
            armed[s]    = 1'b1;
            wait_cnt[s] = 32'(src_q[s][0].gap);
          end
          if (wait_cnt[s] > 0) begin
            wait_cnt[s]--;
          end else begin
            i_tvalid[s] = 1'b1;
            i_tlast[s]  = src_q[s][0].last;
            i_tuser[s]  = src_q[s][0].data;
          end
        end
      end
    end
  end

  // Monitor: records upstream accepts and checks every downstream beat.
  initial begin
    exp_t e;
    acc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc      = '0;
        open_pkt = 1'b0;
      end else begin
        acc = i_tvalid & i_tready;
        chk("tready_onehot0", 32'($onehot0(i_tready)), 32'd1);
        if (o_tvalid && o_tready) begin
          if (open_pkt) chk("no_interleave_tid", 32'(o_tid), 32'(open_tid));
          open_pkt = !o_tlast;
          open_tid = o_tid;
          if (rand_mode) begin
            if (tid_q[o_tid].size() == 0) begin
              fail_now("unexpected_beat_on_tid", 32'(o_tid));
            end else begin
              e = tid_q[o_tid].pop_front();
              chk("rand_tuser", 32'(o_tuser), 32'(e.data));
              chk("rand_tlast", 32'(o_tlast), 32'(e.last));
            end
          end else begin
            if (sb_q.size() == 0) begin
              fail_now("unexpected_beat", 32'(o_tuser));
            end else begin
              e = sb_q.pop_front();
              chk("sb_tid", 32'(o_tid), 32'(e.tid));
              chk("sb_tuser", 32'(o_tuser), 32'(e.data));
              chk("sb_tlast", 32'(o_tlast), 32'(e.last));
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int bubbles;
    int viol;
    int n;
    bit done;
    int cnt [N];
    rst_n     = 1'b0;
    o_tready  = 1'b1;
    rand_mode = 1'b0;
    checks    = 0;
    errors    = 0;

    // Reset values, then a single-beat packet from stream 2.
    push_src(2, 8'h5A, 1'b1, 0);
    push_exp(2, 8'h5A, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("reset_o_tvalid", 32'(o_tvalid), 32'd0);
    chk("reset_o_tlast", 32'(o_tlast), 32'd0);
    chk("reset_o_tuser", 32'(o_tuser), 32'd0);
    chk("reset_o_tid", 32'(o_tid), 32'd0);
    chk("reset_i_tready", 32'(i_tready), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("t1_grant_tready", 32'(i_tready), 32'b0100);
    chk("t1_o_tvalid_pre", 32'(o_tvalid), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_o_tvalid", 32'(o_tvalid), 32'd1);
    chk("t1_o_tuser", 32'(o_tuser), 32'h5A);
    chk("t1_o_tid", 32'(o_tid), 32'd2);
    chk("t1_o_tlast", 32'(o_tlast), 32'd1);
    wait_drain("t1", 20);

    // rr_ptr is 3: stream 3 beats stream 0.
    push_src(0, 8'hA0, 1'b1, 0);
    push_src(3, 8'hA3, 1'b1, 0);
    push_exp(3, 8'hA3, 1'b1);
    push_exp(0, 8'hA0, 1'b1);
    wait_drain("t1b", 20);

    // All streams with 2-beat packets, starting from rr_ptr 1.
    for (int k = 0; k < 4; k++) begin
      int s;
      s = (k + 1) % 4;
      push_src(s, dv(s, 0, 0), 1'b0, 0);
      push_src(s, dv(s, 0, 1), 1'b1, 0);
      push_exp(s, dv(s, 0, 0), 1'b0);
      push_exp(s, dv(s, 0, 1), 1'b1);
    end
    for (int i = 0; i < 20 && !o_tvalid; i++) @(negedge clk);
    bubbles = 0;
    for (int k = 0; k < 8; k++) begin
      if (!o_tvalid) bubbles++;
      @(negedge clk);
    end
    chk("t2_no_bubble", 32'(bubbles), 32'd0);
    wait_drain("t2", 40);

    // Stream 1 locked through a 4-cycle valid gap while stream 0 waits.
    push_src(1, dv(1, 1, 0), 1'b0, 0);
    push_src(1, dv(1, 1, 1), 1'b0, 4);
    push_src(1, dv(1, 1, 2), 1'b1, 0);
    push_src(0, dv(0, 1, 0), 1'b1, 0);
    push_exp(1, dv(1, 1, 0), 1'b0);
    push_exp(1, dv(1, 1, 1), 1'b0);
    push_exp(1, dv(1, 1, 2), 1'b1);
    push_exp(0, dv(0, 1, 0), 1'b1);
    viol = 0;
    done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i_tready[0] && !done) viol++;
      if (i_tvalid[1] && i_tready[1] && i_tlast[1]) done = 1'b1;
    end
    chk("t3_lock_blocks_s0", 32'(viol), 32'd0);
    chk("t3_s1_tlast_seen", 32'(done), 32'd1);
    wait_drain("t3", 20);

    // Downstream stall for 5 cycles with the output loaded.
    @(posedge clk);
    #2 o_tready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      push_src(2, dv(2, 1, b), 1'(b == 2), 0);
      push_exp(2, dv(2, 1, b), 1'(b == 2));
    end
    for (int i = 0; i < 20 && !o_tvalid; i++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_hold_tready", 32'(i_tready), 32'd0);
      chk("t4_hold_tvalid", 32'(o_tvalid), 32'd1);
      chk("t4_hold_tuser", 32'(o_tuser), 32'(dv(2, 1, 0)));
    end
    @(posedge clk);
    #2 o_tready = 1'b1;
    @(negedge clk);
    chk("t4_release_tready", 32'(i_tready), 32'b0100);
    @(posedge clk);
    #1;
    chk("t4_next_tvalid", 32'(o_tvalid), 32'd1);
    chk("t4_next_tuser", 32'(o_tuser), 32'(dv(2, 1, 1)));
    wait_drain("t4", 20);

    // Reset in the middle of a 4-beat packet on stream 3.
    for (int b = 0; b < 4; b++) push_src(3, dv(3, 0, b), 1'(b == 3), 0);
    push_exp(3, dv(3, 0, 0), 1'b0);
    n = 0;
    for (int i = 0; i < 30 && n < 2; i++) begin
      @(negedge clk);
      if (i_tvalid[3] && i_tready[3]) n++;
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_o_tvalid", 32'(o_tvalid), 32'd0);
    chk("t5_rst_o_tuser", 32'(o_tuser), 32'd0);
    chk("t5_rst_o_tid", 32'(o_tid), 32'd0);
    src_q[3].delete();
    push_src(0, 8'hC0, 1'b1, 0);
    push_src(3, 8'hC3, 1'b1, 0);
    push_exp(0, 8'hC0, 1'b1);
    push_exp(3, 8'hC3, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("t5_rst_tready", 32'(i_tready), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    wait_drain("t5", 20);

    // Random packets and back-pressure, checked per source stream.
    rand_mode = 1'b1;
    for (int s = 0; s < N; s++) begin
      cnt[s] = 0;
      for (int p = 0; p < 30; p++) begin
        int len;
        len = int'($urandom_range(1, 4));
        for (int b = 0; b < len; b++) begin
          int gap;
          gap = (b == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 1));
          push_src(s, 8'(cnt[s]), 1'(b == len - 1), gap);
          push_exp(s, 8'(cnt[s]), 1'(b == len - 1));
          cnt[s]++;
        end
      end
    end
    for (int c = 0; c < 4000 && !all_empty(); c++) begin
      @(posedge clk);
      #2 o_tready = ($urandom_range(0, 3) != 0);
    end
    o_tready = 1'b1;
    wait_drain("t6", 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
